// File: rtl/if_stage_pkg.sv
// Shared encodings and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a; the hazard unit's hold codes are defined here.
package if_stage_pkg;

  // Fixed addresses; PC[31] set means kernel mode.
  localparam logic [31:0] RESET_PC_DEF  = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC_DEF = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC_DEF  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  // Next-PC source from ID control. Codes 6 and 7 behave as sequential.
  typedef enum logic [2:0] {
    PCSRC_SEQ    = 3'd0,
    PCSRC_BRANCH = 3'd1,
    PCSRC_JUMP   = 3'd2,
    PCSRC_JR     = 3'd3,
    PCSRC_IRQ    = 3'd4,
    PCSRC_XADR   = 3'd5
  } pcsrc_e;

  // IF/ID register control from the hazard unit. The reserved code flushes.
  typedef enum logic [1:0] {
    IFID_LOAD  = 2'd0,
    IFID_FLUSH = 2'd1,
    IFID_HOLD  = 2'd2,
    IFID_RSVD  = 2'd3
  } ifid_src_e;

  // Sequential increment that leaves the kernel bit alone and wraps
  // inside the low 31 bits.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Combinational next-PC select with fixed priority: exception, interrupt, hold, then control flow.
// Latency: 0 cycles (pure combinational).
// Backpressure: pc_hold freezes PC unless an interrupt or exception is being taken.
//
// Ports:
//   pc, pc_4        current fetch address and its sequential successor
//   id_pc_top       ID_PC_4[31:28], region bits for j/jal
//   pc_src, branch  control-flow selection from ID
//   branch_target, jump_target, jr_target  candidate targets
//   pc_hold         hazard hold request
//   next_pc         address to load into PC at the next edge
import if_stage_pkg::*;

module pc_next_sel #(
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF
) (
  input  logic [31:0] pc,
  input  logic [31:0] pc_4,
  input  logic [3:0]  id_pc_top,
  input  logic [2:0]  pc_src,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        pc_hold,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc_4;
    if (pc_src == PCSRC_XADR) begin
      next_pc = XADR_VEC;
    end else if (pc_src == PCSRC_IRQ) begin
      next_pc = ILLOP_VEC;
    end else if (pc_hold) begin
      // Load-use stall: the jump/branch in ID replays next cycle, so
      // dropping its redirect here loses nothing.
      next_pc = pc;
    end else begin
      case (pc_src)
        PCSRC_BRANCH: next_pc = branch ? branch_target : pc_4;
        // Region comes from the jump's own PC+4, not the fetch PC.
        PCSRC_JUMP:   next_pc = {id_pc_top, jump_target, 2'b00};
        // Full 32-bit load: this is the only way out of kernel mode.
        PCSRC_JR:     next_pc = jr_target;
        default:      next_pc = pc_4;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// IF stage: PC register, next-PC select and IF/ID pipeline register.
// Latency: instruction at PC reaches ID_Instr one cycle later; redirects land on PC at the next edge.
// Backpressure: PCHold freezes PC, IF_ID_Src=2 freezes IF/ID; no handshake with the combinational IM.
//
// Ports:
//   clk, reset    clock; asynchronous active-high reset
//   PCSrc, Branch, BranchTarget, JumpTarget, JrTarget   redirect controls from ID
//   IM_Instr      instruction memory data for address PC
//   PCHold, IF_ID_Src, IF_NoIRQ   hazard unit controls
//   PC            current fetch address
//   ID_Instr, ID_PC_4, ID_NoIRQ   IF/ID register contents
import if_stage_pkg::*;

module if_stage #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] ILLOP_VEC = ILLOP_VEC_DEF,
  parameter logic [31:0] XADR_VEC  = XADR_VEC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  input  logic [25:0] JumpTarget,
  input  logic [31:0] JrTarget,
  input  logic [31:0] IM_Instr,
  input  logic        PCHold,
  input  logic [1:0]  IF_ID_Src,
  input  logic        IF_NoIRQ,
  output logic [31:0] PC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PC_4,
  output logic        ID_NoIRQ
);

  logic [31:0] pc_4;
  logic [31:0] next_pc;

  assign pc_4 = pc_plus4(PC);

  pc_next_sel #(
    .ILLOP_VEC (ILLOP_VEC),
    .XADR_VEC  (XADR_VEC)
  ) u_pc_next_sel (
    .pc            (PC),
    .pc_4          (pc_4),
    .id_pc_top     (ID_PC_4[31:28]),
    .pc_src        (PCSrc),
    .branch        (Branch),
    .branch_target (BranchTarget),
    .jump_target   (JumpTarget),
    .jr_target     (JrTarget),
    .pc_hold       (PCHold),
    .next_pc       (next_pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= RESET_PC;
    end else begin
      PC <= next_pc;
    end
  end

  // Flushed slots still carry PC+4 and the NoIRQ mark so a bubble behind
  // a jump/branch cannot be chosen as an interrupt return point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ID_Instr <= NOP_INSTR;
      ID_PC_4  <= RESET_PC;
      ID_NoIRQ <= 1'b1;
    end else begin
      case (IF_ID_Src)
        IFID_LOAD: begin
          ID_Instr <= IM_Instr;
          ID_PC_4  <= pc_4;
          ID_NoIRQ <= IF_NoIRQ;
        end
        IFID_HOLD: begin
          ID_Instr <= ID_Instr;
          ID_PC_4  <= ID_PC_4;
          ID_NoIRQ <= ID_NoIRQ;
        end
        default: begin
          ID_Instr <= NOP_INSTR;
          ID_PC_4  <= pc_4;
          ID_NoIRQ <= IF_NoIRQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage: reset, sequencing, wrap, redirects, holds and flushes.
// Latency: checks one cycle after each driven vector.
// Backpressure: exercises PCHold and IF/ID hold directly.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic [25:0] JumpTarget;
  logic [31:0] JrTarget;
  logic [31:0] IM_Instr;
  logic        PCHold;
  logic [1:0]  IF_ID_Src;
  logic        IF_NoIRQ;
  logic [31:0] PC;
  logic [31:0] ID_Instr;
  logic [31:0] ID_PC_4;
  logic        ID_NoIRQ;

  int n_cmp = 0;
  int n_err = 0;

  if_stage dut (
    .clk          (clk),
    .reset        (reset),
    .PCSrc        (PCSrc),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .JrTarget     (JrTarget),
    .IM_Instr     (IM_Instr),
    .PCHold       (PCHold),
    .IF_ID_Src    (IF_ID_Src),
    .IF_NoIRQ     (IF_NoIRQ),
    .PC           (PC),
    .ID_Instr     (ID_Instr),
    .ID_PC_4      (ID_PC_4),
    .ID_NoIRQ     (ID_NoIRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] src, input logic br, input logic [31:0] bt,
                       input logic [25:0] jt, input logic [31:0] jr, input logic [31:0] instr,
                       input logic hold, input logic [1:0] ifid, input logic noirq);
    PCSrc        = src;
    Branch       = br;
    BranchTarget = bt;
    JumpTarget   = jt;
    JrTarget     = jr;
    IM_Instr     = instr;
    PCHold       = hold;
    IF_ID_Src    = ifid;
    IF_NoIRQ     = noirq;
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    #3;
    check("rst_pc",     PC,               32'h8000_0000);
    check("rst_instr",  ID_Instr,         32'h0000_0000);
    check("rst_pc4",    ID_PC_4,          32'h8000_0000);
    check("rst_noirq",  {31'd0, ID_NoIRQ}, 32'd1);
    tick();
    reset = 1'b0;

    // Sequential fetch with loads into IF/ID.
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h1111_1111, 1'b0, 2'd0, 1'b0);
    tick();
    check("seq1_pc",    PC,               32'h8000_0004);
    check("seq1_instr", ID_Instr,         32'h1111_1111);
    check("seq1_pc4",   ID_PC_4,          32'h8000_0004);
    check("seq1_noirq", {31'd0, ID_NoIRQ}, 32'd0);
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h2222_2222, 1'b0, 2'd0, 1'b0);
    tick();
    check("seq2_pc",    PC,               32'h8000_0008);
    check("seq2_pc4",   ID_PC_4,          32'h8000_0008);

    // Reset mid-run acts without waiting for an edge.
    reset = 1'b1;
    #1;
    check("mrst_pc",    PC,               32'h8000_0000);
    check("mrst_instr", ID_Instr,         32'h0000_0000);
    check("mrst_noirq", {31'd0, ID_NoIRQ}, 32'd1);
    #1;
    reset = 1'b0;
    tick();
    check("mrst_s1",    PC,               32'h8000_0004);
    tick();
    check("mrst_s2",    PC,               32'h8000_0008);

    // Increment wraps inside 31 bits and keeps the kernel bit.
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h7FFF_FFFC, 32'h0, 1'b0, 2'd1, 1'b0);
    tick();
    check("jr_7ffc",    PC,               32'h7FFF_FFFC);
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    tick();
    check("wrap_user",  PC,               32'h0000_0000);
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'hFFFF_FFFC, 32'h0, 1'b0, 2'd1, 1'b0);
    tick();
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    tick();
    check("wrap_kern",  PC,               32'h8000_0000);

    // Jump with flush: region bits from ID_PC_4 = 0040_0010.
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h0040_000C, 32'h0, 1'b0, 2'd1, 1'b0);
    tick();
    drive(3'd0, 1'b0, 32'h0, 26'h0, 32'h0, 32'h3333_3333, 1'b0, 2'd0, 1'b0);
    tick();
    check("pre_j_pc4",  ID_PC_4,          32'h0040_0010);
    check("pre_j_inst", ID_Instr,         32'h3333_3333);
    drive(3'd2, 1'b0, 32'h0, 26'h100_0004, 32'h0, 32'h4444_4444, 1'b0, 2'd1, 1'b1);
    tick();
    check("j_pc",       PC,               32'h0400_0010);
    check("j_instr",    ID_Instr,         32'h0000_0000);
    check("j_noirq",    {31'd0, ID_NoIRQ}, 32'd1);
    check("j_pc4",      ID_PC_4,          32'h0040_0014);

    // Hold beats jr; everything freezes, then jr replays.
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h0040_0200, 32'h5555_5555, 1'b1, 2'd2, 1'b0);
    tick();
    check("hold_pc",    PC,               32'h0400_0010);
    check("hold_instr", ID_Instr,         32'h0000_0000);
    check("hold_pc4",   ID_PC_4,          32'h0040_0014);
    check("hold_noirq", {31'd0, ID_NoIRQ}, 32'd1);
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h0040_0200, 32'h5555_5555, 1'b0, 2'd0, 1'b0);
    tick();
    check("jr_pc",      PC,               32'h0040_0200);
    check("jr_instr",   ID_Instr,         32'h5555_5555);
    check("jr_pc4",     ID_PC_4,          32'h0400_0014);
    check("jr_noirq",   {31'd0, ID_NoIRQ}, 32'd0);
    drive(3'd1, 1'b1, 32'h0000_1000, 26'h0, 32'h0, 32'h0, 1'b1, 2'd2, 1'b0);
    tick();
    check("hold_br",    PC,               32'h0040_0200);

    // Interrupt and exception override hold; jr leaves kernel mode.
    drive(3'd4, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b1);
    tick();
    check("irq_pc",     PC,               32'h8000_0004);
    drive(3'd5, 1'b0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b1, 2'd1, 1'b1);
    tick();
    check("xadr_pc",    PC,               32'h8000_0008);
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h0040_0000, 32'h0, 1'b0, 2'd1, 1'b0);
    tick();
    check("kexit_pc",   PC,               32'h0040_0000);
    check("kexit_bit",  {31'd0, PC[31]},  32'd0);

    // Branch not taken, then taken.
    drive(3'd3, 1'b0, 32'h0, 26'h0, 32'h0040_0020, 32'h0, 1'b0, 2'd1, 1'b0);
    tick();
    drive(3'd1, 1'b0, 32'h0040_0100, 26'h0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0);
    tick();
    check("bnt_pc",     PC,               32'h0040_0024);
    drive(3'd1, 1'b1, 32'h0040_0100, 26'h0, 32'h0, 32'h0, 1'b0, 2'd1, 1'b1);
    tick();
    check("bt_pc",      PC,               32'h0040_0100);

    // Unused PCSrc code is sequential; reserved IF/ID code flushes.
    drive(3'd6, 1'b0, 32'h0, 26'h0, 32'h0, 32'h6666_6666, 1'b0, 2'd3, 1'b1);
    tick();
    check("src6_pc",    PC,               32'h0040_0104);
    check("rsv_instr",  ID_Instr,         32'h0000_0000);
    check("rsv_pc4",    ID_PC_4,          32'h0040_0104);
    check("rsv_noirq",  {31'd0, ID_NoIRQ}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
